// File: rtl/kws_decision_smoother.sv
// Sliding-window per-class score smoother with argmax/threshold/hold-off decision.
// Optional KWS_SMOOTH_STATS_EN adds a saturating detect_count output.
module kws_decision_smoother #(
    parameter int NUM_CLASSES    = 4,
    parameter int SCORE_WIDTH    = 16,
    parameter int WIN_DEPTH      = 8,
    parameter int HOLDOFF_FRAMES = 16,
    parameter int CLASS_W        = $clog2(NUM_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SCORE_WIDTH-1:0] score_in,
    input  logic                   score_valid,
    output logic                   score_ready,
    input  logic                   clear,
    input  logic [SCORE_WIDTH-1:0] threshold,
    output logic                   keyword_detected,
    output logic [CLASS_W-1:0]     keyword_class,
    output logic [SCORE_WIDTH-1:0] smoothed_score
`ifdef KWS_SMOOTH_STATS_EN
    ,
    output logic [15:0]            detect_count
`endif
);

    localparam int LOG_W  = $clog2(WIN_DEPTH);
    localparam int SUM_W  = SCORE_WIDTH + LOG_W;
    localparam int FILL_W = $clog2(WIN_DEPTH + 1);
    localparam int HO_W   = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [CLASS_W-1:0] LAST_CLS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [FILL_W-1:0]  FULL     = FILL_W'(WIN_DEPTH);
    localparam logic [HO_W-1:0]    HO_INIT  = HO_W'(HOLDOFF_FRAMES);

    typedef enum logic {COLLECT, DECIDE} state_e;

    state_e                 state_q, state_d;
    logic [CLASS_W-1:0]     cls_q, cls_d;
    logic [LOG_W-1:0]       wptr_q, wptr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [HO_W-1:0]        holdoff_q, holdoff_d;
    logic [SUM_W-1:0]       sum_q [NUM_CLASSES];
    logic [SUM_W-1:0]       sum_d [NUM_CLASSES];
    logic [CLASS_W-1:0]     best_cls_q, best_cls_d;
    logic [SCORE_WIDTH-1:0] best_mean_q, best_mean_d;
    logic                   det_q, det_d;
    logic [CLASS_W-1:0]     kw_cls_q, kw_cls_d;
    logic [SCORE_WIDTH-1:0] sm_q, sm_d;
    logic [SCORE_WIDTH-1:0] win_mem [NUM_CLASSES][WIN_DEPTH];

    logic                   accept;
    logic [SCORE_WIDTH-1:0] oldest;
    logic [SUM_W-1:0]       sum_new;
    logic [SCORE_WIDTH-1:0] mean_new;

    assign score_ready      = (state_q == COLLECT);
    assign accept           = score_valid && score_ready && !clear;
    // Until the window has filled, the slot being replaced holds no real frame.
    assign oldest           = (fill_q == FULL) ? win_mem[cls_q][wptr_q] : '0;
    assign sum_new          = sum_q[cls_q] + SUM_W'(score_in) - SUM_W'(oldest);
    assign mean_new         = SCORE_WIDTH'(sum_new >> LOG_W);
    assign keyword_detected = det_q;
    assign keyword_class    = kw_cls_q;
    assign smoothed_score   = sm_q;

    always_ff @(posedge clk) begin
        if (accept) win_mem[cls_q][wptr_q] <= score_in;
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        holdoff_d   = holdoff_q;
        sum_d       = sum_q;
        best_cls_d  = best_cls_q;
        best_mean_d = best_mean_q;
        det_d       = 1'b0;
        kw_cls_d    = kw_cls_q;
        sm_d        = sm_q;
        if (clear) begin
            state_d     = COLLECT;
            cls_d       = '0;
            wptr_d      = '0;
            fill_d      = '0;
            holdoff_d   = '0;
            best_cls_d  = '0;
            best_mean_d = '0;
            for (int i = 0; i < NUM_CLASSES; i++) sum_d[i] = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        sum_d[cls_q] = sum_new;
                        if (cls_q == '0 || mean_new > best_mean_q) begin
                            best_cls_d  = cls_q;
                            best_mean_d = mean_new;
                        end
                        if (cls_q == LAST_CLS) begin
                            cls_d   = '0;
                            state_d = DECIDE;
                        end else begin
                            cls_d = cls_q + 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    state_d = COLLECT;
                    wptr_d  = wptr_q + 1'b1;
                    fill_d  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
                    sm_d    = best_mean_q;
                    if (fill_d == FULL && best_cls_q != '0 &&
                        best_mean_q >= threshold && holdoff_q == '0) begin
                        det_d     = 1'b1;
                        kw_cls_d  = best_cls_q;
                        holdoff_d = HO_INIT;
                    end else if (holdoff_q != '0) begin
                        holdoff_d = holdoff_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cls_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            holdoff_q   <= '0;
            best_cls_q  <= '0;
            best_mean_q <= '0;
            det_q       <= 1'b0;
            kw_cls_q    <= '0;
            sm_q        <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) sum_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            holdoff_q   <= holdoff_d;
            best_cls_q  <= best_cls_d;
            best_mean_q <= best_mean_d;
            det_q       <= det_d;
            kw_cls_q    <= kw_cls_d;
            sm_q        <= sm_d;
            for (int i = 0; i < NUM_CLASSES; i++) sum_q[i] <= sum_d[i];
        end
    end

`ifdef KWS_SMOOTH_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) cnt_d = '0;
        else if (det_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign detect_count = cnt_q;
`endif

endmodule

// File: tb/tb_kws_decision_smoother.sv
// Scoreboard bench for kws_decision_smoother: driver queues hand-computed
// per-frame results, a negedge monitor pops them after each decision cycle.
module tb_kws_decision_smoother;

    localparam int NC = 4;
    localparam int SW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] score_in = '0;
    logic          score_valid = 1'b0;
    logic          score_ready;
    logic          clear = 1'b0;
    logic [SW-1:0] threshold = 16'd100;
    logic          keyword_detected;
    logic [CW-1:0] keyword_class;
    logic [SW-1:0] smoothed_score;
`ifdef KWS_SMOOTH_STATS_EN
    logic [15:0]   detect_count;
`endif

    kws_decision_smoother #(
        .NUM_CLASSES(NC),
        .SCORE_WIDTH(SW),
        .WIN_DEPTH(4),
        .HOLDOFF_FRAMES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .score_in(score_in),
        .score_valid(score_valid),
        .score_ready(score_ready),
        .clear(clear),
        .threshold(threshold),
        .keyword_detected(keyword_detected),
        .keyword_class(keyword_class),
        .smoothed_score(smoothed_score)
`ifdef KWS_SMOOTH_STATS_EN
        ,
        .detect_count(detect_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit det;
        int cls;
        int sm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: the cycle after score_ready drops carries the frame decision.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_decision", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("detected", int'(keyword_detected), int'(e.det));
                    chk("class", int'(keyword_class), e.cls);
                    chk("smoothed", int'(smoothed_score), e.sm);
                end
            end else begin
                chk("no_pulse", int'(keyword_detected), 0);
            end
            pend = !score_ready;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int s);
        bit ok;
        ok = 0;
        score_in = SW'(s);
        score_valid = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (score_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        score_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 0, 1);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d,
                         input bit det, input int cls, input int sm);
        exp_t e;
        send(a);
        send(b);
        send(c);
        send(d);
        e.det = det;
        e.cls = cls;
        e.sm = sm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(score_ready), 1);
        chk("rst_detected", int'(keyword_detected), 0);
        chk("rst_class", int'(keyword_class), 0);
        chk("rst_smoothed", int'(smoothed_score), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Warm-up then hold-off
        frame(0, 0, 200, 0, 0, 0, 50);
        frame(0, 0, 200, 0, 0, 0, 100);
        frame(0, 0, 200, 0, 0, 0, 150);
        frame(0, 0, 200, 0, 1, 2, 200);
        frame(0, 0, 200, 0, 0, 2, 200);
        frame(0, 0, 200, 0, 0, 2, 200);
        frame(0, 0, 200, 0, 0, 2, 200);
        frame(0, 0, 200, 0, 1, 2, 200);
        idle(3);

        // Async reset mid-frame
        send(0);
        send(0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(score_ready), 1);
        chk("midrst_detected", int'(keyword_detected), 0);
        chk("midrst_class", int'(keyword_class), 0);
        chk("midrst_smoothed", int'(smoothed_score), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Background dominates: never reported
        frame(300, 0, 0, 0, 0, 0, 75);
        frame(300, 0, 0, 0, 0, 0, 150);
        frame(300, 0, 0, 0, 0, 0, 225);
        frame(300, 0, 0, 0, 0, 0, 300);
        frame(300, 0, 0, 0, 0, 0, 300);

        // Tie between class 1 and 3 goes to class 1
        frame(0, 150, 0, 150, 0, 0, 225);
        frame(0, 150, 0, 150, 0, 0, 150);
        frame(0, 150, 0, 150, 1, 1, 112);
        frame(0, 150, 0, 150, 0, 1, 150);
        frame(0, 150, 0, 150, 0, 1, 150);
        frame(0, 150, 0, 150, 0, 1, 150);
        frame(0, 150, 0, 150, 1, 1, 150);
        idle(3);

        // Mean exactly at threshold detects
        do_clear();
        frame(0, 200, 0, 0, 0, 1, 50);
        frame(0, 200, 0, 0, 0, 1, 100);
        frame(0, 0, 0, 0, 0, 1, 100);
        frame(0, 0, 0, 0, 1, 1, 100);
        idle(3);

        // Mean one below threshold does not
        do_clear();
        frame(0, 199, 0, 0, 0, 1, 49);
        frame(0, 199, 0, 0, 0, 1, 99);
        frame(0, 0, 0, 0, 0, 1, 99);
        frame(0, 0, 0, 0, 0, 1, 99);
        idle(3);

        // Clear mid-frame, colliding with a valid score that must be dropped
        send(0);
        send(0);
        clear = 1'b1;
        score_valid = 1'b1;
        score_in = 16'd500;
        @(posedge clk);
        #1;
        clear = 1'b0;
        score_valid = 1'b0;
        @(negedge clk);
        chk("clear_keeps_class", int'(keyword_class), 1);
        chk("clear_keeps_smoothed", int'(smoothed_score), 99);
`ifdef KWS_SMOOTH_STATS_EN
        chk("clear_count", int'(detect_count), 0);
`endif
        @(posedge clk);
        #1;
        frame(0, 0, 200, 0, 0, 1, 50);
        frame(0, 0, 200, 0, 0, 1, 100);
        frame(0, 0, 200, 0, 0, 1, 150);
        frame(0, 0, 200, 0, 1, 2, 200);
        idle(4);

        chk("queue_drained", exp_q.size(), 0);
`ifdef KWS_SMOOTH_STATS_EN
        chk("final_count", int'(detect_count), 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
